branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-side partner of branch_pred_unit.
- Carries each fetched instruction's prediction metadata through ID to EX.
- Compares the prediction against the resolved branch outcome and raises flush/redirect on a mispredict.
- Drives the predictor's training port (ADDR_EX, Pred_EX, state_change, state_write, branch) plus GHP repair and statistics counters.

Parameters:
- GHP_W, 4, global history width; matches the predictor's ghp.
- FLUSH_CYCLES, 2, cycles spent in RECOVER after a mispredict (1..7).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch slot holds a real instruction
- if_pc  in  32  fetch PC
- if_hit  in  1  predictor BTB hit
- if_taken  in  1  predictor direction
- if_pred_addr  in  32  predicted target
- if_ghp  in  GHP_W  history snapshot at fetch
- pipe_stall  in  1  hold ID/EX metadata stages
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved taken target
- ADDR_EX  out  32  PC of the trained branch
- Pred_EX  out  32  target written to BTB
- state_change  out  1  update 2-bit counter
- state_write  out  1  install/overwrite BTB entry
- branch  out  1  actual outcome for training
- flush  out  1  squash IF/ID, one-cycle pulse
- redirect_pc  out  32  correct fetch PC, valid with flush
- ghp_restore  out  GHP_W  repaired history, valid with flush
- br_count  out  CNT_W  resolved branches
- mp_count  out  CNT_W  mispredicts

Behaviour:
- Reset (rst=0, async): all outputs 0, both metadata stages invalid, FSM=RUN, counters 0.
- Metadata pipe: stages id_m and ex_m each hold {v, pc, hit, taken, pred_addr, ghp}.
  - When !pipe_stall, on each edge: id_m <= IF inputs with v=if_valid, and ex_m <= id_m.
  - When pipe_stall: both stages hold.
  - IF data reaches ex_m two non-stalled edges after capture.
- Resolve qualifier R = ex_valid & ex_is_branch & ex_m.v & !pipe_stall & FSM==RUN.
- Derived signals:
  - pred_t = ex_m.hit & ex_m.taken.
  - mispredict = R & ((pred_t != ex_taken) | (pred_t & ex_taken & ex_m.pred_addr != ex_target)).
- Registered outputs (latency 1: valid in the cycle after R), all single-cycle pulses, otherwise 0:
  - branch = ex_taken.
  - ADDR_EX = ex_m.pc.
  - Pred_EX = ex_target.
  - state_change = R & ex_m.hit.
  - state_write = R & ex_taken & (!ex_m.hit | ex_m.pred_addr != ex_target).
  - ADDR_EX and Pred_EX hold their last value when idle.
- On mispredict, next cycle:
  - flush = 1.
  - redirect_pc = ex_taken ? ex_target : ex_m.pc + 4 (32-bit wrap).
  - ghp_restore = {ex_m.ghp[GHP_W-2:0], ex_taken}.
- FSM:
  - RUN -> RECOVER on mispredict; load cnt = FLUSH_CYCLES.
  - In RECOVER: invalidate id_m/ex_m every cycle (even under pipe_stall), ignore ex inputs, decrement cnt.
  - RECOVER -> RUN when cnt reaches 1.
  - A flush/invalidate takes priority over pipe_stall.
- Counters: br_count += R; mp_count += mispredict; both saturate at all-ones, never wrap.
- Non-branch, or ex_valid without ex_m.v: no training, no flush.
- Reset asserted mid-RECOVER: returns immediately to RUN with cleared state; no pending pulse survives.

Decomposition:
- Shared package holds:
  - GHP_W and XLEN=32.
  - Metadata struct/field widths.
  - FSM state encoding (RUN=0, RECOVER=1).
  - The PC increment constant 4.
- One natural sub-module: bru_meta_stage, a single valid/stall/clear pipeline register, instantiated twice for ID and EX.

Test Plan:
- Correct predict: IF pc=0xfe941ee3, hit=1, taken=1, pred=0x00140413; two edges later ex_taken=1, target=0x00140413 -> next cycle state_change=1, state_write=0, branch=1, flush=0; br_count=1.
- BTB miss taken: IF pc=0x00090463, hit=0; EX taken=1, target=0xfff90913 -> state_write=1, Pred_EX=0xfff90913, flush=1, redirect_pc=0xfff90913, mp_count=1.
- Predicted taken, actual not: hit=1, taken=1, ghp=4'b1010, pc=0x00090463; ex_taken=0 -> flush=1, redirect_pc=0x00090467, ghp_restore=4'b0100, state_change=1, branch=0.
- Target mismatch: hit=1, taken=1, pred=0x100; ex_target=0x200 -> flush=1, state_write=1, Pred_EX=0x200; then FLUSH_CYCLES=2 cycles in which ex_valid & ex_is_branch produce no outputs.
- pipe_stall held 3 cycles with a resolving branch in EX -> no outputs until stall drops, then exactly one training pulse.
- Assert rst during RECOVER -> all outputs 0 immediately; after release, a correct-predict branch trains normally; counters restart at 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int XLEN  = 32;
  localparam int GHP_W = 4;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } bru_state_e;

  // Prediction metadata travelling alongside an instruction from IF to EX.
  // The valid bit sits in the MSB so the remaining fields form one data slice.
  typedef struct packed {
    logic             v;
    logic [XLEN-1:0]  pc;
    logic             hit;
    logic             taken;
    logic [XLEN-1:0]  pred_addr;
    logic [GHP_W-1:0] ghp;
  } meta_t;

endpackage

// File: rtl/bru_meta_stage.sv
// One metadata pipeline register with stall (hold) and clear (invalidate).
// Clear wins over hold so a squash is never delayed by a stall.
module bru_meta_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         adv_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Capture on advance, drop the valid bit on clear, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: compares carried prediction metadata with the
// resolved outcome, trains the predictor, and flushes/redirects on mispredict.
//
// state   | meaning
// RUN     | normal operation, branches in EX are resolved
// RECOVER | squashing wrong-path metadata for FLUSH_CYCLES cycles
module branch_resolve_unit #(
  parameter int GHP_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_hit,
  input  logic             if_taken,
  input  logic [31:0]      if_pred_addr,
  input  logic [GHP_W-1:0] if_ghp,
  input  logic             pipe_stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic [31:0]      ADDR_EX,
  output logic [31:0]      Pred_EX,
  output logic             state_change,
  output logic             state_write,
  output logic             branch,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [GHP_W-1:0] ghp_restore,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  import branch_resolve_unit_pkg::*;

  localparam int         DATA_W     = $bits(meta_t) - 1;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  meta_t             if_m;
  meta_t             ex_m;
  logic              id_v;
  logic              ex_v;
  logic [DATA_W-1:0] id_data;
  logic [DATA_W-1:0] ex_data;

  bru_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic resolve;
  logic pred_t;
  logic tgt_diff;
  logic mispredict;
  logic meta_clr;
  logic unused_ghp_msb;

  logic [31:0]      addr_q, addr_d;
  logic [31:0]      pred_ex_q, pred_ex_d;
  logic             sc_q, sc_d;
  logic             sw_q, sw_d;
  logic             branch_q, branch_d;
  logic             flush_q, flush_d;
  logic [31:0]      redir_q, redir_d;
  logic [GHP_W-1:0] ghp_q, ghp_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  assign if_m = '{v: if_valid, pc: if_pc, hit: if_hit, taken: if_taken,
                  pred_addr: if_pred_addr, ghp: if_ghp};

  // The wrong-path instruction captured on the mispredict edge is dropped too.
  assign meta_clr = (state_q == ST_RECOVER) | mispredict;

  bru_meta_stage #(.W(DATA_W)) u_id_stage (
    .clk_i   (clk),
    .rst_ni  (rst),
    .adv_i   (!pipe_stall),
    .clr_i   (meta_clr),
    .valid_i (if_m.v),
    .data_i  (if_m[DATA_W-1:0]),
    .valid_o (id_v),
    .data_o  (id_data)
  );

  bru_meta_stage #(.W(DATA_W)) u_ex_stage (
    .clk_i   (clk),
    .rst_ni  (rst),
    .adv_i   (!pipe_stall),
    .clr_i   (meta_clr),
    .valid_i (id_v),
    .data_i  (id_data),
    .valid_o (ex_v),
    .data_o  (ex_data)
  );

  assign ex_m = meta_t'({ex_v, ex_data});

  assign unused_ghp_msb = ex_m.ghp[GHP_W-1];

  assign resolve    = ex_valid & ex_is_branch & ex_m.v & !pipe_stall & (state_q == ST_RUN);
  assign pred_t     = ex_m.hit & ex_m.taken;
  assign tgt_diff   = ex_m.pred_addr != ex_target;
  assign mispredict = resolve & ((pred_t != ex_taken) | (pred_t & ex_taken & tgt_diff));

  // Next state: enter RECOVER on mispredict, count down to the terminal value 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RUN) begin
      if (mispredict) begin
        state_d = ST_RECOVER;
        cnt_d   = FLUSH_LOAD;
      end
    end else begin
      if (cnt_q == 3'd1) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  // Next values for training/flush pulses and saturating statistics.
  always_comb begin
    addr_d    = addr_q;
    pred_ex_d = pred_ex_q;
    sc_d      = resolve & ex_m.hit;
    sw_d      = resolve & ex_taken & (!ex_m.hit | tgt_diff);
    branch_d  = resolve & ex_taken;
    flush_d   = mispredict;
    redir_d   = '0;
    ghp_d     = '0;
    br_cnt_d  = br_cnt_q;
    mp_cnt_d  = mp_cnt_q;
    if (resolve) begin
      addr_d    = ex_m.pc;
      pred_ex_d = ex_target;
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_ONE;
    end
    if (mispredict) begin
      redir_d = ex_taken ? ex_target : ex_m.pc + PC_INC;
      ghp_d   = {ex_m.ghp[GHP_W-2:0], ex_taken};
      if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      pred_ex_q <= '0;
      sc_q      <= 1'b0;
      sw_q      <= 1'b0;
      branch_q  <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= '0;
      ghp_q     <= '0;
      br_cnt_q  <= '0;
      mp_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      pred_ex_q <= pred_ex_d;
      sc_q      <= sc_d;
      sw_q      <= sw_d;
      branch_q  <= branch_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      ghp_q     <= ghp_d;
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
    end
  end

  assign ADDR_EX      = addr_q;
  assign Pred_EX      = pred_ex_q;
  assign state_change = sc_q;
  assign state_write  = sw_q;
  assign branch       = branch_q;
  assign flush        = flush_q;
  assign redirect_pc  = redir_q;
  assign ghp_restore  = ghp_q;
  assign br_count     = br_cnt_q;
  assign mp_count     = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences for
// stall / recovery / reset, and randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  localparam int GHP_W        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             if_valid = 1'b0;
  logic [31:0]      if_pc = '0;
  logic             if_hit = 1'b0;
  logic             if_taken = 1'b0;
  logic [31:0]      if_pred_addr = '0;
  logic [GHP_W-1:0] if_ghp = '0;
  logic             pipe_stall = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_is_branch = 1'b0;
  logic             ex_taken = 1'b0;
  logic [31:0]      ex_target = '0;
  logic [31:0]      ADDR_EX;
  logic [31:0]      Pred_EX;
  logic             state_change;
  logic             state_write;
  logic             branch;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [GHP_W-1:0] ghp_restore;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  int n_vec = 0;
  int n_bad = 0;

  branch_resolve_unit #(.GHP_W(GHP_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_hit       (if_hit),
    .if_taken     (if_taken),
    .if_pred_addr (if_pred_addr),
    .if_ghp       (if_ghp),
    .pipe_stall   (pipe_stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_taken     (ex_taken),
    .ex_target    (ex_target),
    .ADDR_EX      (ADDR_EX),
    .Pred_EX      (Pred_EX),
    .state_change (state_change),
    .state_write  (state_write),
    .branch       (branch),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .ghp_restore  (ghp_restore),
    .br_count     (br_count),
    .mp_count     (mp_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic             v;
    logic [31:0]      pc;
    logic             hit;
    logic             taken;
    logic [31:0]      pred;
    logic [GHP_W-1:0] ghp;
  } md_t;

  md_t              m_id, m_ex;
  int               m_rec;
  int               m_br, m_mp;
  logic [31:0]      m_addr, m_predex, m_redir;
  logic             m_sc, m_sw, m_branch, m_flush;
  logic [GHP_W-1:0] m_ghp;

  task automatic model_reset();
    m_id    = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0};
    m_ex    = m_id;
    m_rec   = 0;
    m_br    = 0;
    m_mp    = 0;
    m_addr  = '0;
    m_predex = '0;
    m_redir = '0;
    m_sc    = 1'b0;
    m_sw    = 1'b0;
    m_branch = 1'b0;
    m_flush = 1'b0;
    m_ghp   = '0;
  endtask

  // Predicts the outputs that appear after the coming clock edge.
  task automatic model_step();
    logic r, pt, mp;
    r  = ex_valid && ex_is_branch && m_ex.v && !pipe_stall && (m_rec == 0);
    pt = m_ex.hit && m_ex.taken;
    mp = r && ((pt != ex_taken) || (pt && ex_taken && (m_ex.pred != ex_target)));
    m_branch = r && ex_taken;
    m_sc     = r && m_ex.hit;
    m_sw     = r && ex_taken && (!m_ex.hit || (m_ex.pred != ex_target));
    if (r) begin
      m_addr   = m_ex.pc;
      m_predex = ex_target;
      if (m_br < CNT_MAX) m_br++;
    end
    m_flush = mp;
    m_redir = !mp ? 32'h0 : (ex_taken ? ex_target : m_ex.pc + 32'd4);
    m_ghp   = mp ? {m_ex.ghp[GHP_W-2:0], ex_taken} : '0;
    if (mp && m_mp < CNT_MAX) m_mp++;
    if (m_rec > 0) begin
      m_rec--;
      m_id.v = 1'b0;
      m_ex.v = 1'b0;
    end else begin
      if (mp) m_rec = FLUSH_CYCLES;
      if (!pipe_stall) begin
        m_ex = m_id;
        m_id = '{if_valid, if_pc, if_hit, if_taken, if_pred_addr, if_ghp};
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ADDR_EX", ADDR_EX, m_addr);
    check("Pred_EX", Pred_EX, m_predex);
    check("state_change", 32'(state_change), 32'(m_sc));
    check("state_write", 32'(state_write), 32'(m_sw));
    check("branch", 32'(branch), 32'(m_branch));
    check("flush", 32'(flush), 32'(m_flush));
    check("redirect_pc", redirect_pc, m_redir);
    check("ghp_restore", 32'(ghp_restore), 32'(m_ghp));
    check("br_count", 32'(br_count), 32'(m_br));
    check("mp_count", 32'(mp_count), 32'(m_mp));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    if_valid     = 1'b0;
    pipe_stall   = 1'b0;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_taken     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_if(input logic [31:0] pc, input logic hit, input logic tk,
                         input logic [31:0] pred, input logic [GHP_W-1:0] ghp);
    if_valid     = 1'b1;
    if_pc        = pc;
    if_hit       = hit;
    if_taken     = tk;
    if_pred_addr = pred;
    if_ghp       = ghp;
  endtask

  task automatic drive_ex(input logic tk, input logic [31:0] tgt);
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_taken     = tk;
    ex_target    = tgt;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0]      pc;
    logic             hit;
    logic             taken;
    logic [31:0]      pred;
    logic [GHP_W-1:0] ghp;
    logic             ex_tk;
    logic [31:0]      tgt;
    logic             e_flush;
    logic [31:0]      e_redir;
    logic [GHP_W-1:0] e_ghp;
    logic             e_sc;
    logic             e_sw;
    logic             e_br;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'hfe941ee3, 1'b1, 1'b1, 32'h00140413, 4'h0, 1'b1, 32'h00140413, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h00090463, 1'b0, 1'b0, 32'h00000000, 4'h3, 1'b1, 32'hfff90913, 1'b1, 32'hfff90913, 4'h7, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{32'h00090463, 1'b1, 1'b1, 32'h00000100, 4'ha, 1'b0, 32'h00000100, 1'b1, 32'h00090467, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h00000080, 1'b1, 1'b1, 32'h00000100, 4'h0, 1'b1, 32'h00000200, 1'b1, 32'h00000200, 4'h1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{32'hfffffffc, 1'b1, 1'b1, 32'h00000040, 4'hf, 1'b0, 32'h00000044, 1'b1, 32'h00000000, 4'he, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h00001000, 1'b1, 1'b0, 32'h00002000, 4'h5, 1'b0, 32'h00002000, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h00003000, 1'b0, 1'b1, 32'h00000000, 4'h6, 1'b0, 32'h00003100, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00004000, 1'b1, 1'b0, 32'h00004800, 4'h9, 1'b1, 32'h00004800, 1'b1, 32'h00004800, 4'h3, 1'b1, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      load_if(tbl[i].pc, tbl[i].hit, tbl[i].taken, tbl[i].pred, tbl[i].ghp);
      cycle();
      if_valid = 1'b0;
      cycle();
      drive_ex(tbl[i].ex_tk, tbl[i].tgt);
      cycle();
      check($sformatf("vec%0d.flush", i), 32'(flush), 32'(tbl[i].e_flush));
      check($sformatf("vec%0d.redirect", i), redirect_pc, tbl[i].e_redir);
      check($sformatf("vec%0d.ghp", i), 32'(ghp_restore), 32'(tbl[i].e_ghp));
      check($sformatf("vec%0d.sc", i), 32'(state_change), 32'(tbl[i].e_sc));
      check($sformatf("vec%0d.sw", i), 32'(state_write), 32'(tbl[i].e_sw));
      check($sformatf("vec%0d.branch", i), 32'(branch), 32'(tbl[i].e_br));
      check($sformatf("vec%0d.addr", i), ADDR_EX, tbl[i].pc);
      check($sformatf("vec%0d.pred_ex", i), Pred_EX, tbl[i].tgt);
      check($sformatf("vec%0d.br_count", i), 32'(br_count), 32'd1);
      check($sformatf("vec%0d.mp_count", i), 32'(mp_count), 32'(tbl[i].e_flush));
      idle_inputs();
      repeat (FLUSH_CYCLES + 1) cycle();
      check($sformatf("vec%0d.pulse_end", i), 32'({state_change, state_write, branch, flush}), 32'd0);
    end

    // Recovery window ignores EX even with a live branch and valid fetch stream.
    do_reset();
    load_if(32'h00000500, 1'b1, 1'b1, 32'h00000100, 4'h2);
    cycle();
    cycle();
    drive_ex(1'b1, 32'h00000200);
    cycle();
    check("rec.flush", 32'(flush), 32'd1);
    ex_target = 32'h00000100;
    for (int k = 0; k < FLUSH_CYCLES; k++) begin
      cycle();
      check($sformatf("rec.quiet%0d", k), 32'({state_change, state_write, branch, flush}), 32'd0);
    end
    cycle();
    check("rec.refill1", 32'(state_change), 32'd0);
    cycle();
    check("rec.refill2", 32'(state_change), 32'd0);
    cycle();
    check("rec.train", 32'(state_change), 32'd1);
    check("rec.br_count", 32'(br_count), 32'd2);
    check("rec.mp_count", 32'(mp_count), 32'd1);

    // Stall holds a resolving branch; exactly one pulse once it drops.
    do_reset();
    load_if(32'h00000600, 1'b1, 1'b1, 32'h00000500, 4'h1);
    cycle();
    if_valid = 1'b0;
    cycle();
    drive_ex(1'b1, 32'h00000500);
    pipe_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("stall.hold%0d", k), 32'({state_change, branch}), 32'd0);
    end
    pipe_stall = 1'b0;
    cycle();
    check("stall.pulse", 32'({state_change, branch}), 32'b11);
    cycle();
    check("stall.once", 32'({state_change, branch}), 32'd0);
    check("stall.br_count", 32'(br_count), 32'd1);

    // Reset asserted mid-RECOVER clears everything at once.
    do_reset();
    load_if(32'h00000700, 1'b0, 1'b0, 32'h0, 4'h5);
    cycle();
    if_valid = 1'b0;
    cycle();
    drive_ex(1'b1, 32'h00000777);
    cycle();
    check("rstrec.flush_before", 32'(flush), 32'd1);
    ex_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rstrec.flush", 32'(flush), 32'd0);
    check("rstrec.redirect", redirect_pc, 32'd0);
    check("rstrec.sw", 32'(state_write), 32'd0);
    check("rstrec.mp_count", 32'(mp_count), 32'd0);
    check("rstrec.addr", ADDR_EX, 32'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    load_if(32'h00000800, 1'b1, 1'b1, 32'h00000900, 4'h0);
    cycle();
    if_valid = 1'b0;
    cycle();
    drive_ex(1'b1, 32'h00000900);
    cycle();
    check("rstrec.train_sc", 32'(state_change), 32'd1);
    check("rstrec.train_flush", 32'(flush), 32'd0);
    check("rstrec.br_count", 32'(br_count), 32'd1);
    check("rstrec.mp_after", 32'(mp_count), 32'd0);

    // Back-to-back correct branches saturate br_count at all-ones.
    do_reset();
    load_if(32'h00000a00, 1'b1, 1'b1, 32'h00000b00, 4'h0);
    drive_ex(1'b1, 32'h00000b00);
    repeat (CNT_MAX + 6) cycle();
    check("sat.br_count", 32'(br_count), 32'(CNT_MAX));
    check("sat.mp_count", 32'(mp_count), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if_valid     = ($urandom_range(0, 9) < 7);
      if_pc        = $urandom() & 32'hffff_fffc;
      if_hit       = $urandom_range(0, 1) == 1;
      if_taken     = $urandom_range(0, 1) == 1;
      if_pred_addr = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h200;
      if_ghp       = GHP_W'($urandom_range(0, (1 << GHP_W) - 1));
      pipe_stall   = ($urandom_range(0, 9) < 2);
      ex_valid     = ($urandom_range(0, 9) < 7);
      ex_is_branch = ($urandom_range(0, 9) < 7);
      ex_taken     = $urandom_range(0, 1) == 1;
      ex_target    = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h200;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
